pci_conf_cyc_target: RTL and testbench
======================================

# pci_conf_cyc_target

Type-0 PCI configuration-cycle responder: the target-side counterpart of the configuration address decoder that drives one-hot IDSEL on AD[31:11]. The block sits in a PCI device's target interface. It samples address phases, claims configuration read/write cycles addressed to it via IDSEL, runs the TRDY#/DEVSEL#/STOP# handshake and serves a 16-dword configuration register file. It exports the command register to the rest of the device.

## Interface
Parameters:
- VENDOR_ID, 16'h1895, read-only value for dword 0 [15:0]
- DEVICE_ID, 16'h0001, read-only value for dword 0 [31:16]
- CLASS_REV, 32'h0680_0001, read-only value for dword 2

Ports:
- pci_clk_in  in  1  PCI clock; all state updates on rising edge
- reset_in  in  1  asynchronous, active-high reset
- frame_n_in  in  1  FRAME#, sampled
- irdy_n_in  in  1  IRDY#, sampled
- idsel_in  in  1  IDSEL for this device
- ad_in  in  32  AD bus, sampled
- cbe_n_in  in  4  C/BE#, sampled
- ad_out  out  32  read data
- ad_oe  out  1  AD output enable
- par_out  out  1  even parity over ad_out and cbe_n_in
- par_oe  out  1  PAR output enable
- trdy_n_out, devsel_n_out, stop_n_out  out  1 each  target control signals
- ctrl_oe  out  1  shared enable for TRDY#/DEVSEL#/STOP#
- cmd_reg  out  3  command register bits [2:0] (IO, MEM, master enable)

## Operation
- Address phase = cycle with frame_n_in 0 whose previous sample was 1, and bus in IDLE.
- Claim condition: idsel_in=1, cbe_n_in=4'b1010 (cfg read) or 4'b1011 (cfg write), ad_in[1:0]=2'b00, ad_in[10:8]=3'b000. Latch reg index = ad_in[5:2], out_of_range = ad_in[7:6]!=0, and read/write.
- No claim -> state BUSY until frame_n_in=1 and irdy_n_in=1, then IDLE. No control outputs are driven.
- States: IDLE, BUSY, TURN (read turnaround), DATA, BACKOFF.
- IDLE -> TURN (read) or DATA (write) on claim. TURN -> DATA after 1 cycle.
- DATA: TRDY# low. Transfer completes on the edge where irdy_n_in=0. If frame_n_in is still 0 at that edge, STOP# is asserted with TRDY# (disconnect-with-data; single data phase only) and held until frame_n_in=1. Then -> BACKOFF.
- BACKOFF: TRDY#/DEVSEL#/STOP# driven 1 for one cycle, ctrl_oe=1. Then ctrl_oe=0 -> IDLE.
- Register map:
  - dword 0 = {DEVICE_ID,VENDOR_ID}, RO.
  - dword 1 = {16'h0, 13'h0, cmd[2:0]}; only byte 0 bits [2:0] are writable.
  - dword 2 = CLASS_REV, RO.
  - dwords 4–7 = 32-bit R/W scratch.
  - All other indices, and out_of_range, read 0 and ignore writes.
- Writes honor byte enables: a byte is written only when its cbe_n_in bit is 0 at the completing edge.
- Reset values: all outputs 0 except trdy_n_out, devsel_n_out and stop_n_out, which reset to 1. cmd=0, scratch=0, state IDLE.
- Reset mid-transaction: all enables drop immediately (asynchronous). No register write occurs.

## Timing
- Address phase at edge A:
  - devsel_n_out=0 and ctrl_oe=1 from A+1.
  - Write: trdy_n_out=0 from A+1.
  - Read: ad_oe=1 from A+2, with ad_out valid and trdy_n_out=0 from A+2 (A+1 is turnaround).
- Read: par_out/par_oe valid the cycle after each cycle ad_oe=1. par_oe stays 1 one cycle after ad_oe falls.
- ad_oe drops on the cycle after the completing edge.
- Write data takes effect on the completing edge; cmd_reg updates the next cycle.
- irdy_n_in held 1: DATA waits indefinitely; no target timeout.
- Simultaneous address phase during BACKOFF: ignored (bus not IDLE); the master retries.

## Structure
- Package pci_conf_pkg holds:
  - cfg command codes (CMD_CFG_RD=4'hA, CMD_CFG_WR=4'hB)
  - register indices (REG_ID, REG_CMD, REG_CLASS, REG_SCR_FIRST/LAST)
  - state enum
- Sub-module pci_conf_regfile: indexed read mux, byte-enabled write, cmd output.
- Top module holds the FSM, decode latches, output drivers and parity.

## Test plan
- Cfg read dword 0, idsel=1, cbe=A, AD=0x0000_0000 -> devsel low at A+1, trdy low and ad_out=0x0001_1895 at A+2, par_out correct at A+3, BACKOFF then ctrl_oe=0.
- Cfg write dword 5 = 0xDEAD_BEEF with cbe=4'b0101 (bytes 1,3 enabled) -> readback 0xDE00_BE00.
- Cfg write dword 1 = 0xFFFF_FFFF, all bytes -> cmd_reg=3'b111, readback 0x0000_0007.
- idsel=0 or cbe=4'h6 or ad[1:0]=01 -> devsel_n_out stays 1, ctrl_oe stays 0, state returns IDLE after frame/irdy high.
- Burst attempt: frame_n held 0 at completion -> stop_n_out=0 together with trdy, held until frame_n=1; only one dword is transferred.
- irdy_n held 1 for 5 cycles then 0 -> trdy stays low throughout; assert reset_in mid-DATA -> all enables 0 immediately, scratch unchanged.

Source files
------------

// File: rtl/pci_conf_pkg.sv
// Shared constants and state encoding for the type-0 configuration-cycle target.
package pci_conf_pkg;
   localparam logic [3:0] CMD_CFG_RD = 4'hA;
   localparam logic [3:0] CMD_CFG_WR = 4'hB;

   localparam logic [3:0] REG_ID        = 4'd0;
   localparam logic [3:0] REG_CMD       = 4'd1;
   localparam logic [3:0] REG_CLASS     = 4'd2;
   localparam logic [3:0] REG_SCR_FIRST = 4'd4;
   localparam logic [3:0] REG_SCR_LAST  = 4'd7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BUSY,
      ST_TURN,
      ST_DATA,
      ST_BACKOFF
   } state_e;
endpackage

// File: rtl/pci_conf_cyc_target_if.sv
// PCI target-side bus signals; master drives the sampled inputs, slave the target outputs.
interface pci_conf_cyc_target_if;
   logic        frame_n_in;
   logic        irdy_n_in;
   logic        idsel_in;
   logic [31:0] ad_in;
   logic [3:0]  cbe_n_in;
   logic [31:0] ad_out;
   logic        ad_oe;
   logic        par_out;
   logic        par_oe;
   logic        trdy_n_out;
   logic        devsel_n_out;
   logic        stop_n_out;
   logic        ctrl_oe;

   modport master (
      output frame_n_in, irdy_n_in, idsel_in, ad_in, cbe_n_in,
      input  ad_out, ad_oe, par_out, par_oe, trdy_n_out, devsel_n_out, stop_n_out, ctrl_oe
   );
   modport slave (
      input  frame_n_in, irdy_n_in, idsel_in, ad_in, cbe_n_in,
      output ad_out, ad_oe, par_out, par_oe, trdy_n_out, devsel_n_out, stop_n_out, ctrl_oe
   );
endinterface

// File: rtl/pci_conf_regfile.sv
// 16-dword configuration space: fixed ID/class words, command bits and four scratch dwords.
module pci_conf_regfile
   import pci_conf_pkg::*;
#(
   parameter logic [15:0] VENDOR_ID = 16'h1895,
   parameter logic [15:0] DEVICE_ID = 16'h0001,
   parameter logic [31:0] CLASS_REV = 32'h0680_0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [3:0]  idx,
   input  logic        oor,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic [31:0] rdata,
   output logic [2:0]  cmd
);
   logic [2:0]       cmd_q, cmd_d;
   logic [3:0][31:0] scr_q, scr_d;

   always_comb begin
      cmd_d = cmd_q;
      scr_d = scr_q;
      if (wr_en && !oor) begin
         if (idx == REG_CMD && be[0]) cmd_d = wdata[2:0];
         if (idx >= REG_SCR_FIRST && idx <= REG_SCR_LAST) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) scr_d[idx[1:0]][8*b +: 8] = wdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (!oor) begin
         if (idx == REG_ID)         rdata = {DEVICE_ID, VENDOR_ID};
         else if (idx == REG_CMD)   rdata = {29'h0, cmd_q};
         else if (idx == REG_CLASS) rdata = CLASS_REV;
         else if (idx >= REG_SCR_FIRST && idx <= REG_SCR_LAST) rdata = scr_q[idx[1:0]];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_q <= '0;
         scr_q <= '0;
      end else begin
         cmd_q <= cmd_d;
         scr_q <= scr_d;
      end
   end

   assign cmd = cmd_q;
endmodule

// File: rtl/pci_conf_cyc_target.sv
// Type-0 configuration-cycle target: claims IDSEL cycles, runs DEVSEL#/TRDY#/STOP#, serves the regfile.
module pci_conf_cyc_target
   import pci_conf_pkg::*;
#(
   parameter logic [15:0] VENDOR_ID = 16'h1895,
   parameter logic [15:0] DEVICE_ID = 16'h0001,
   parameter logic [31:0] CLASS_REV = 32'h0680_0001
) (
   input  logic                       pci_clk_in,
   input  logic                       reset_in,
   pci_conf_cyc_target_if.slave       bus,
   output logic [2:0]                 cmd_reg
);
   state_e      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic        oor_q, oor_d;
   logic        rd_q, rd_d;
   logic        done_q, done_d;
   logic        frame_prev_q, frame_prev_d;
   logic        par_q, par_d;
   logic        par_oe_q, par_oe_d;
   logic        wr_en, addr_phase, claim, ad_oe;
   logic [31:0] rdata;

   assign addr_phase = !bus.frame_n_in && frame_prev_q;
   assign claim = bus.idsel_in && (bus.cbe_n_in == CMD_CFG_RD || bus.cbe_n_in == CMD_CFG_WR) &&
                  bus.ad_in[1:0] == 2'b00 && bus.ad_in[10:8] == 3'b000;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      oor_d        = oor_q;
      rd_d         = rd_q;
      done_d       = done_q;
      frame_prev_d = bus.frame_n_in;
      wr_en        = 1'b0;
      unique case (state_q)
         ST_IDLE: if (addr_phase) begin
            if (claim) begin
               idx_d   = bus.ad_in[5:2];
               oor_d   = |bus.ad_in[7:6];
               rd_d    = (bus.cbe_n_in == CMD_CFG_RD);
               done_d  = 1'b0;
               state_d = (bus.cbe_n_in == CMD_CFG_RD) ? ST_TURN : ST_DATA;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: if (bus.frame_n_in && bus.irdy_n_in) state_d = ST_IDLE;
         ST_TURN: state_d = ST_DATA;
         ST_DATA: begin
            // done_q marks the disconnect hold: the single dword is already
            // transferred, STOP# stays low until the master drops FRAME#.
            if (!done_q) begin
               if (!bus.irdy_n_in) begin
                  wr_en = !rd_q;
                  if (!bus.frame_n_in) done_d = 1'b1;
                  else                 state_d = ST_BACKOFF;
               end
            end else if (bus.frame_n_in) begin
               state_d = ST_BACKOFF;
            end
         end
         ST_BACKOFF: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   assign ad_oe    = (state_q == ST_DATA) && rd_q && !done_q;
   assign par_d    = ad_oe ? ^{rdata, bus.cbe_n_in} : 1'b0;
   assign par_oe_d = ad_oe;

   always_ff @(posedge pci_clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         oor_q        <= 1'b0;
         rd_q         <= 1'b0;
         done_q       <= 1'b0;
         frame_prev_q <= 1'b1;
         par_q        <= 1'b0;
         par_oe_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         oor_q        <= oor_d;
         rd_q         <= rd_d;
         done_q       <= done_d;
         frame_prev_q <= frame_prev_d;
         par_q        <= par_d;
         par_oe_q     <= par_oe_d;
      end
   end

   pci_conf_regfile #(
      .VENDOR_ID (VENDOR_ID),
      .DEVICE_ID (DEVICE_ID),
      .CLASS_REV (CLASS_REV)
   ) u_regfile (
      .clk   (pci_clk_in),
      .rst   (reset_in),
      .wr_en (wr_en),
      .idx   (idx_q),
      .oor   (oor_q),
      .wdata (bus.ad_in),
      .be    (~bus.cbe_n_in),
      .rdata (rdata),
      .cmd   (cmd_reg)
   );

   assign bus.ad_oe        = ad_oe;
   assign bus.ad_out       = ad_oe ? rdata : '0;
   assign bus.par_out      = par_q;
   assign bus.par_oe       = par_oe_q;
   assign bus.ctrl_oe      = (state_q == ST_TURN) || (state_q == ST_DATA) || (state_q == ST_BACKOFF);
   assign bus.devsel_n_out = !((state_q == ST_TURN) || (state_q == ST_DATA));
   assign bus.trdy_n_out   = !(state_q == ST_DATA);
   assign bus.stop_n_out   = !((state_q == ST_DATA) && done_q);
endmodule

// File: tb/tb_pci_conf_cyc_target.sv
// Randomized bench for pci_conf_cyc_target with a config-space model kept as plain arrays.
module tb_pci_conf_cyc_target;
   import pci_conf_pkg::*;

   localparam logic [15:0] VEN = 16'h1895;
   localparam logic [15:0] DEV = 16'h0001;
   localparam logic [31:0] CLS = 32'h0680_0001;

   logic pci_clk_in = 1'b0;
   logic reset_in;
   logic [2:0] cmd_reg;
   int n_chk = 0;
   int n_pass = 0;

   logic [31:0] mdl_scr [4];
   logic [2:0]  mdl_cmd;

   pci_conf_cyc_target_if bus_if ();

   pci_conf_cyc_target dut (
      .pci_clk_in (pci_clk_in),
      .reset_in   (reset_in),
      .bus        (bus_if),
      .cmd_reg    (cmd_reg)
   );

   always #5 pci_clk_in = ~pci_clk_in;

   task automatic tick;
      @(posedge pci_clk_in);
      #1;
   endtask

   function automatic logic [31:0] exp_rd(input logic [3:0] idx, input bit oor);
      if (oor) return 32'h0;
      case (idx)
         4'd0: return {DEV, VEN};
         4'd1: return {29'h0, mdl_cmd};
         4'd2: return CLS;
         4'd4, 4'd5, 4'd6, 4'd7: return mdl_scr[idx - 4];
         default: return 32'h0;
      endcase
   endfunction

   task automatic mdl_write(input logic [3:0] idx, input bit oor, input logic [31:0] d, input logic [3:0] be_n);
      if (oor) return;
      if (idx == 4'd1 && !be_n[0]) mdl_cmd = d[2:0];
      if (idx >= 4 && idx <= 7)
         for (int b = 0; b < 4; b++)
            if (!be_n[b]) mdl_scr[idx - 4][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic mdl_reset;
      for (int i = 0; i < 4; i++) mdl_scr[i] = 32'h0;
      mdl_cmd = 3'b000;
   endtask

   task automatic bus_idle;
      bus_if.frame_n_in = 1'b1;
      bus_if.irdy_n_in  = 1'b1;
      bus_if.idsel_in   = 1'b0;
      bus_if.ad_in      = 32'h0;
      bus_if.cbe_n_in   = 4'hF;
   endtask

   task automatic addr_phase(input bit rd, input logic [3:0] idx, input bit oor);
      logic [1:0] oorb;
      oorb = oor ? 2'($urandom_range(1, 3)) : 2'b00;
      bus_if.frame_n_in = 1'b0;
      bus_if.irdy_n_in  = 1'b1;
      bus_if.idsel_in   = 1'b1;
      bus_if.cbe_n_in   = rd ? CMD_CFG_RD : CMD_CFG_WR;
      bus_if.ad_in      = {21'($urandom), 3'b000, oorb, idx, 2'b00};
   endtask

   // One complete single-dword transaction with timing checks along the way.
   task automatic do_xfer(input bit rd, input logic [3:0] idx, input bit oor, input logic [31:0] data,
                          input logic [3:0] be_n, input int waits, input bit burst, output logic [31:0] got);
      logic [31:0] exp;
      exp = exp_rd(idx, oor);
      got = 32'hx;
      addr_phase(rd, idx, oor);
      tick;
      n_chk++;
      if ({bus_if.devsel_n_out, bus_if.ctrl_oe, bus_if.trdy_n_out, bus_if.ad_oe} !== {1'b0, 1'b1, rd, 1'b0})
         $display("FAIL a+1 idx=%0d rd=%0d: devsel,oe,trdy,ad_oe=%b want %b", idx, rd,
                  {bus_if.devsel_n_out, bus_if.ctrl_oe, bus_if.trdy_n_out, bus_if.ad_oe}, {1'b0, 1'b1, rd, 1'b0});
      else n_pass++;
      bus_if.idsel_in = 1'b0;
      bus_if.cbe_n_in = be_n;
      bus_if.ad_in    = rd ? $urandom : data;
      if (rd) begin
         tick;
         got = bus_if.ad_out;
         n_chk++;
         if ({bus_if.ad_oe, bus_if.trdy_n_out, bus_if.ad_out} !== {1'b1, 1'b0, exp})
            $display("FAIL read a+2 idx=%0d oor=%0d: oe=%b trdy=%b ad=%h want ad=%h", idx, oor,
                     bus_if.ad_oe, bus_if.trdy_n_out, bus_if.ad_out, exp);
         else n_pass++;
      end
      for (int w = 0; w < waits; w++) begin
         bus_if.frame_n_in = 1'b0;
         bus_if.irdy_n_in  = 1'b1;
         tick;
         n_chk++;
         if ({bus_if.trdy_n_out, bus_if.devsel_n_out, bus_if.stop_n_out} !== 3'b001 ||
             (rd && {bus_if.ad_out, bus_if.par_oe, bus_if.par_out} !== {exp, 1'b1, ^{exp, be_n}}))
            $display("FAIL wait %0d idx=%0d: trdy,devsel,stop=%b ad=%h par_oe=%b", w, idx,
                     {bus_if.trdy_n_out, bus_if.devsel_n_out, bus_if.stop_n_out}, bus_if.ad_out, bus_if.par_oe);
         else n_pass++;
      end
      bus_if.frame_n_in = burst ? 1'b0 : 1'b1;
      bus_if.irdy_n_in  = 1'b0;
      tick;
      if (!rd) mdl_write(idx, oor, data, be_n);
      n_chk++;
      if (bus_if.ad_oe !== 1'b0 || cmd_reg !== mdl_cmd ||
          (rd && {bus_if.par_oe, bus_if.par_out} !== {1'b1, ^{exp, be_n}}))
         $display("FAIL after completion idx=%0d: ad_oe=%b cmd=%b want %b par_oe=%b par=%b want %b",
                  idx, bus_if.ad_oe, cmd_reg, mdl_cmd, bus_if.par_oe, bus_if.par_out, ^{exp, be_n});
      else n_pass++;
      if (burst) begin
         bus_if.ad_in    = $urandom;
         bus_if.cbe_n_in = 4'h0;
         for (int h = 0; h < 2; h++) begin
            n_chk++;
            if ({bus_if.stop_n_out, bus_if.trdy_n_out, bus_if.devsel_n_out, bus_if.ctrl_oe} !== 4'b0001)
               $display("FAIL burst hold %0d: stop,trdy,devsel,oe=%b want 0001", h,
                        {bus_if.stop_n_out, bus_if.trdy_n_out, bus_if.devsel_n_out, bus_if.ctrl_oe});
            else n_pass++;
            if (h == 0) tick;
         end
         bus_if.frame_n_in = 1'b1;
         bus_if.irdy_n_in  = 1'b1;
         tick;
      end else begin
         bus_if.irdy_n_in = 1'b1;
      end
      n_chk++;
      if ({bus_if.trdy_n_out, bus_if.devsel_n_out, bus_if.stop_n_out, bus_if.ctrl_oe} !== 4'b1111)
         $display("FAIL backoff: trdy,devsel,stop,oe=%b want 1111",
                  {bus_if.trdy_n_out, bus_if.devsel_n_out, bus_if.stop_n_out, bus_if.ctrl_oe});
      else n_pass++;
      bus_idle();
      tick;
      n_chk++;
      if ({bus_if.ctrl_oe, bus_if.ad_oe, bus_if.par_oe} !== 3'b000)
         $display("FAIL idle after backoff: oe,ad_oe,par_oe=%b want 000",
                  {bus_if.ctrl_oe, bus_if.ad_oe, bus_if.par_oe});
      else n_pass++;
      tick;
   endtask

   task automatic test_reset;
      n_chk++;
      if ({bus_if.trdy_n_out, bus_if.devsel_n_out, bus_if.stop_n_out, bus_if.ctrl_oe, bus_if.ad_oe,
           bus_if.par_oe, bus_if.par_out, bus_if.ad_out, cmd_reg} !== {3'b111, 4'b0000, 32'h0, 3'b000})
         $display("FAIL reset state: ctrl=%b oe=%b ad=%h cmd=%b",
                  {bus_if.trdy_n_out, bus_if.devsel_n_out, bus_if.stop_n_out}, bus_if.ctrl_oe, bus_if.ad_out, cmd_reg);
      else n_pass++;
   endtask

   task automatic test_read_id;
      logic [31:0] got;
      do_xfer(1'b1, 4'd0, 1'b0, 32'h0, 4'h0, 0, 1'b0, got);
      n_chk++;
      if (got !== 32'h0001_1895) $display("FAIL read id: got %h want 00011895", got);
      else n_pass++;
   endtask

   task automatic test_write_bytes;
      logic [31:0] got;
      do_xfer(1'b0, 4'd5, 1'b0, 32'hDEAD_BEEF, 4'b0101, 0, 1'b0, got);
      do_xfer(1'b1, 4'd5, 1'b0, 32'h0, 4'h0, 1, 1'b0, got);
      n_chk++;
      if (got !== 32'hDE00_BE00) $display("FAIL byte enables: got %h want de00be00", got);
      else n_pass++;
   endtask

   task automatic test_cmd_write;
      logic [31:0] got;
      do_xfer(1'b0, 4'd1, 1'b0, 32'hFFFF_FFFF, 4'h0, 0, 1'b0, got);
      n_chk++;
      if (cmd_reg !== 3'b111) $display("FAIL cmd_reg: got %b want 111", cmd_reg);
      else n_pass++;
      do_xfer(1'b1, 4'd1, 1'b0, 32'h0, 4'h0, 0, 1'b0, got);
      n_chk++;
      if (got !== 32'h0000_0007) $display("FAIL cmd readback: got %h want 00000007", got);
      else n_pass++;
   endtask

   task automatic test_no_claim;
      logic [31:0] got;
      for (int v = 0; v < 4; v++) begin
         addr_phase(1'b1, 4'd0, 1'b0);
         case (v)
            0: bus_if.idsel_in = 1'b0;
            1: bus_if.cbe_n_in = 4'h6;
            2: bus_if.ad_in[1:0] = 2'b01;
            default: bus_if.ad_in[10:8] = 3'b010;
         endcase
         for (int c = 0; c < 3; c++) begin
            tick;
            bus_if.irdy_n_in = 1'b0;
            bus_if.idsel_in  = 1'b1;
            n_chk++;
            if ({bus_if.devsel_n_out, bus_if.ctrl_oe, bus_if.ad_oe} !== 3'b100)
               $display("FAIL no-claim v%0d c%0d: devsel,oe,ad_oe=%b want 100", v, c,
                        {bus_if.devsel_n_out, bus_if.ctrl_oe, bus_if.ad_oe});
            else n_pass++;
         end
         bus_idle();
         tick;
         tick;
      end
      do_xfer(1'b1, 4'd2, 1'b0, 32'h0, 4'h0, 0, 1'b0, got);
      n_chk++;
      if (got !== CLS) $display("FAIL class after no-claim: got %h want %h", got, CLS);
      else n_pass++;
   endtask

   task automatic test_burst;
      logic [31:0] got;
      do_xfer(1'b0, 4'd6, 1'b0, 32'h1234_5678, 4'h0, 1, 1'b1, got);
      do_xfer(1'b1, 4'd6, 1'b0, 32'h0, 4'h0, 0, 1'b1, got);
      n_chk++;
      if (got !== 32'h1234_5678) $display("FAIL burst single dword: got %h want 12345678", got);
      else n_pass++;
   endtask

   task automatic test_backoff_addr;
      addr_phase(1'b0, 4'd7, 1'b0);
      tick;
      bus_if.idsel_in = 1'b0;
      bus_if.ad_in = 32'hCAFE_0001;
      bus_if.cbe_n_in = 4'h0;
      bus_if.frame_n_in = 1'b1;
      bus_if.irdy_n_in = 1'b0;
      tick;
      mdl_write(4'd7, 1'b0, 32'hCAFE_0001, 4'h0);
      addr_phase(1'b1, 4'd0, 1'b0);
      for (int c = 0; c < 2; c++) begin
         tick;
         n_chk++;
         if ({bus_if.devsel_n_out, bus_if.ctrl_oe} !== 2'b10)
            $display("FAIL addr in backoff c%0d: devsel,oe=%b want 10", c, {bus_if.devsel_n_out, bus_if.ctrl_oe});
         else n_pass++;
      end
      bus_idle();
      tick;
      tick;
   endtask

   task automatic test_wait_reset;
      logic [31:0] got;
      do_xfer(1'b0, 4'd4, 1'b0, 32'hA5A5_5A5A, 4'h0, 5, 1'b0, got);
      addr_phase(1'b1, 4'd4, 1'b0);
      tick;
      bus_if.idsel_in = 1'b0;
      bus_if.cbe_n_in = 4'h0;
      bus_if.frame_n_in = 1'b0;
      tick;
      tick;
      #2 reset_in = 1'b1;
      #1;
      mdl_reset();
      n_chk++;
      if ({bus_if.ad_oe, bus_if.ctrl_oe, bus_if.par_oe, bus_if.trdy_n_out, bus_if.devsel_n_out,
           bus_if.stop_n_out, cmd_reg} !== {6'b000111, 3'b000})
         $display("FAIL async reset mid-data: oe=%b ctrl=%b cmd=%b",
                  {bus_if.ad_oe, bus_if.ctrl_oe, bus_if.par_oe},
                  {bus_if.trdy_n_out, bus_if.devsel_n_out, bus_if.stop_n_out}, cmd_reg);
      else n_pass++;
      bus_idle();
      tick;
      reset_in = 1'b0;
      tick;
      do_xfer(1'b1, 4'd4, 1'b0, 32'h0, 4'h0, 0, 1'b0, got);
      n_chk++;
      if (got !== 32'h0) $display("FAIL scratch after reset: got %h want 0", got);
      else n_pass++;
   endtask

   task automatic test_random;
      logic [31:0] got;
      logic [3:0]  idx;
      bit          oor;
      for (int i = 0; i < 24; i++) begin
         idx = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) idx = 4'($urandom_range(4, 7));
         oor = ($urandom_range(0, 7) == 0);
         do_xfer(1'b0, idx, oor, $urandom, 4'($urandom), $urandom_range(0, 3), ($urandom_range(0, 4) == 0), got);
         do_xfer(1'b1, idx, $urandom_range(0, 5) == 0, 32'h0, 4'($urandom), $urandom_range(0, 2),
                 ($urandom_range(0, 4) == 0), got);
      end
   endtask

   initial begin
      bus_idle();
      mdl_reset();
      reset_in = 1'b1;
      tick;
      test_reset();
      tick;
      reset_in = 1'b0;
      tick;
      test_read_id();
      test_write_bytes();
      test_cmd_write();
      test_no_claim();
      test_burst();
      test_backoff_addr();
      test_wait_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
